reg_pipe: RTL and testbench
===========================

# reg_pipe

Parametrised WIDTH x DEPTH delay line: a chain of enable-gated D registers with a valid bit per stage, synchronous active-low reset, synchronous flush, a runtime-selectable tap and an occupancy count. It replaces single-bit D flip-flops wherever the design needs a multi-bit, multi-cycle registered delay with stall and flush control, such as aligning side-band data to a pipelined datapath.

## Interface
- WIDTH, 8, data width in bits (>= 1)
- DEPTH, 4, number of register stages (>= 1)
- RESET_VAL, 0, value loaded into every data stage by reset and by flush (WIDTH bits)
- clk  input  1  clock, all state updates on rising edge
- syn_reset_n  input  1  reset, synchronous and active-low
- en  input  1  advance enable; 0 = stall (hold all stages)
- flush  input  1  synchronous clear of all stages
- d  input  WIDTH  data into stage 0
- d_valid  input  1  qualifies d
- tap_sel  input  TW  stage index for tap outputs; TW = max(1, clog2(DEPTH))
- q  output  WIDTH  data of stage DEPTH-1
- q_valid  output  1  valid of stage DEPTH-1
- tap_q  output  WIDTH  data of stage tap_sel (combinational mux of registers)
- tap_valid  output  1  valid of stage tap_sel
- count  output  CW  number of valid stages; CW = clog2(DEPTH+1)

## Operation
- State: data[0..DEPTH-1] (WIDTH each), vld[0..DEPTH-1].
- Priority per rising edge: reset > flush > en > hold.
- Reset (syn_reset_n=0 at edge): all data = RESET_VAL, all vld = 0, count = 0. Reset is sampled only on the clock edge; asserting it between edges has no effect until the next edge.
- Flush (reset inactive, flush=1): same result as reset. d/d_valid in that cycle are discarded even if en=1.
- Advance (en=1, no flush): data[0]<=d, vld[0]<=d_valid; data[i]<=data[i-1], vld[i]<=vld[i-1]. Stage DEPTH-1 contents drop off.
- Stall (en=0): all stages hold, including count. d is ignored.
- Invalid entries still shift data (no bubble collapsing). Data in a stage with vld=0 is don't-care to consumers but is deterministic for verification.
- count next = popcount(next vld). It is held in a register and must equal popcount(vld) every cycle. Incremental update is allowed: +d_valid, -vld[DEPTH-1] on advance.
- tap_sel >= DEPTH (non-power-of-2 DEPTH): tap_q = RESET_VAL, tap_valid = 0.
- DEPTH=1: q = tap_q = data[0]; tap_sel is ignored.

## Timing
- Latency d -> q: exactly DEPTH enabled edges. Stalled cycles add no entries, so latency in clocks is DEPTH + number of en=0 cycles.
- Latency d -> tap_q at tap_sel=k: k+1 enabled edges.
- All outputs are registered except tap_q and tap_valid, which are a mux on registered state with tap_sel. That mux is the only combinational input->output path.
- Reset values: q = RESET_VAL, q_valid = 0, count = 0, tap_q = RESET_VAL, tap_valid = 0 (for any tap_sel).
- A reset or flush mid-stream loses all in-flight entries. The first entry accepted after release appears on q DEPTH enabled edges later.
- Simultaneous flush and d_valid with en=1: the entry is dropped and count = 0 next cycle.

## Structure
- Shared package reg_pipe_pkg: width helper function clog2 and the TW/CW derivation (max(1, clog2(DEPTH)), clog2(DEPTH+1)). Both are reused by future parametrised register blocks.
- One sub-module, reg_pipe_stage: WIDTH-bit data plus valid flop with en, clear (load RESET_VAL, valid=0) and synchronous active-low reset. It is instantiated DEPTH times with a generate loop.
- Top level holds the count register, the tap mux and output assigns.

## Test plan
- Reset: WIDTH=8, DEPTH=4, RESET_VAL=8'hA5, syn_reset_n=0 for 2 edges -> q=8'hA5, q_valid=0, count=0. Pulse syn_reset_n low between edges only -> no state change.
- Streaming: en=1, d_valid=1, d=1,2,3,4,5 on consecutive edges -> q=1 with q_valid=1 on the 4th edge after d=1 is sampled, then 2,3,4,5. count rises 1,2,3,4 and holds at 4.
- Stall: while streaming, en=0 for 3 cycles -> q, count and all taps frozen. After en=1 resumes, the sequence continues with no loss or duplication.
- Flush collision: pipeline full (count=4), flush=1 with en=1, d_valid=1, d=8'h77 -> next cycle count=0, q_valid=0, q=RESET_VAL, and 8'h77 never appears on q.
- Tap and bubbles: d_valid pattern 1,0,1,1 with d=10,11,12,13. Sweep tap_sel 0..3 -> tap_valid/tap_q match the shifted pattern, count=3. Then DEPTH=3, tap_sel=3 -> tap_valid=0, tap_q=RESET_VAL.
- Reset mid-operation: full pipeline, syn_reset_n=0 for one edge with flush=1 and en=1 -> same result as reset. After release, a single entry reaches q after exactly DEPTH enabled edges.

Source files
------------

// File: rtl/reg_pipe_pkg.sv
//==============================================================================
// Module   : reg_pipe_pkg
// Purpose  : Width helpers shared by parametrised register blocks.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package reg_pipe_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int tap_width(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_pipe_if.sv
//==============================================================================
// Module   : reg_pipe_if
// Purpose  : Data, control and tap bundle of the reg_pipe delay line.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface reg_pipe_if
    import reg_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int TW = tap_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic             en;
    logic             flush;
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic [TW-1:0]    tap_sel;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [WIDTH-1:0] tap_q;
    logic             tap_valid;
    logic [CW-1:0]    count;

    modport master (
        output en, flush, d, d_valid, tap_sel,
        input  q, q_valid, tap_q, tap_valid, count
    );

    modport slave (
        input  en, flush, d, d_valid, tap_sel,
        output q, q_valid, tap_q, tap_valid, count
    );

endinterface

`default_nettype wire

// File: rtl/reg_pipe_stage.sv
//==============================================================================
// Module   : reg_pipe_stage
// Purpose  : One enable-gated data + valid register with clear and reset.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module reg_pipe_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  wire logic             clk,
    input  wire logic             syn_reset_n,
    input  wire logic             en,
    input  wire logic             clear,
    input  wire logic [WIDTH-1:0] din,
    input  wire logic             vin,
    output logic      [WIDTH-1:0] dout,
    output logic                  vout
);

    logic [WIDTH-1:0] r_data;
    logic             r_vld;

    always_ff @(posedge clk) begin
        if (!syn_reset_n || clear) begin
            r_data <= RESET_VAL;
            r_vld  <= 1'b0;
        end else if (en) begin
            r_data <= din;
            r_vld  <= vin;
        end
    end

    assign dout = r_data;
    assign vout = r_vld;

endmodule

`default_nettype wire

// File: rtl/reg_pipe.sv
//==============================================================================
// Module   : reg_pipe
// Purpose  : WIDTH x DEPTH stallable, flushable delay line with tap and count.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  wire logic  clk,
    input  wire logic  syn_reset_n,
    reg_pipe_if.slave  bus
);

    localparam int TW = tap_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] w_data [DEPTH];
    logic             w_vld  [DEPTH];
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] w_tap_q;
    logic             w_tap_v;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] w_din;
        logic             w_vin;

        if (i == 0) begin : g_head
            assign w_din = bus.d;
            assign w_vin = bus.d_valid;
        end else begin : g_link
            assign w_din = w_data[i-1];
            assign w_vin = w_vld[i-1];
        end

        reg_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk         (clk),
            .syn_reset_n (syn_reset_n),
            .en          (bus.en),
            .clear       (bus.flush),
            .din         (w_din),
            .vin         (w_vin),
            .dout        (w_data[i]),
            .vout        (w_vld[i])
        );
    end

    // Incremental occupancy: one entry in, the last stage's entry out.
    always_ff @(posedge clk) begin
        if (!syn_reset_n || bus.flush) begin
            r_count <= '0;
        end else if (bus.en) begin
            r_count <= r_count + CW'(bus.d_valid) - CW'(w_vld[DEPTH-1]);
        end
    end

    if (DEPTH == 1) begin : g_tap_single
        assign w_tap_q = w_data[0];
        assign w_tap_v = w_vld[0];
    end else begin : g_tap_mux
        // Out-of-range selects (non power-of-2 DEPTH) fall through to the default.
        always_comb begin
            w_tap_q = RESET_VAL;
            w_tap_v = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.tap_sel == TW'(i)) begin
                    w_tap_q = w_data[i];
                    w_tap_v = w_vld[i];
                end
            end
        end
    end

    assign bus.q         = w_data[DEPTH-1];
    assign bus.q_valid   = w_vld[DEPTH-1];
    assign bus.tap_q     = w_tap_q;
    assign bus.tap_valid = w_tap_v;
    assign bus.count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_reg_pipe.sv
//==============================================================================
// Module   : tb_reg_pipe
// Purpose  : Directed vector-table bench for reg_pipe (DEPTH 4 and DEPTH 3).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_reg_pipe;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       fl;
        logic [7:0] d;
        logic       dv;
        logic [1:0] ts;
        logic [7:0] eq;
        logic       eqv;
        logic [2:0] ecnt;
        logic [7:0] etq;
        logic       etv;
    } vec_t;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   n_tests;
    int   n_fail;
    vec_t vecs[$];

    reg_pipe_if #(.WIDTH(8), .DEPTH(4)) bus_a ();
    reg_pipe_if #(.WIDTH(8), .DEPTH(3)) bus_b ();

    reg_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) dut_a (
        .clk         (clk),
        .syn_reset_n (rst_a),
        .bus         (bus_a)
    );

    reg_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h3C)) dut_b (
        .clk         (clk),
        .syn_reset_n (rst_b),
        .bus         (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic f, input logic [7:0] d,
                       input logic dv, input logic [1:0] ts, input logic [7:0] eq,
                       input logic eqv, input logic [2:0] ecnt, input logic [7:0] etq,
                       input logic etv);
        vec_t v;
        v.rst_n = r; v.en = e; v.fl = f; v.d = d; v.dv = dv; v.ts = ts;
        v.eq = eq; v.eqv = eqv; v.ecnt = ecnt; v.etq = etq; v.etv = etv;
        vecs.push_back(v);
    endtask

    task automatic drive_a(input logic r, input logic e, input logic f, input logic [7:0] d,
                           input logic dv, input logic [1:0] ts);
        rst_a         = r;
        bus_a.en      = e;
        bus_a.flush   = f;
        bus_a.d       = d;
        bus_a.d_valid = dv;
        bus_a.tap_sel = ts;
    endtask

    initial begin
        int hit;
        int en_edges;
        logic [7:0] q_seen;

        n_tests = 0;
        n_fail  = 0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        drive_a(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0);
        bus_b.en = 1'b0; bus_b.flush = 1'b0; bus_b.d = 8'h00;
        bus_b.d_valid = 1'b0; bus_b.tap_sel = 2'd0;

        //   rst en fl  d     dv ts     q     qv cnt  tap_q tv
        add(0, 0, 0, 8'h00, 0, 0,  8'hA5, 0, 0, 8'hA5, 0);
        add(0, 1, 0, 8'h00, 1, 3,  8'hA5, 0, 0, 8'hA5, 0);
        add(1, 1, 0, 8'h01, 1, 0,  8'hA5, 0, 1, 8'h01, 1);
        add(1, 1, 0, 8'h02, 1, 1,  8'hA5, 0, 2, 8'h01, 1);
        add(1, 1, 0, 8'h03, 1, 2,  8'hA5, 0, 3, 8'h01, 1);
        add(1, 1, 0, 8'h04, 1, 3,  8'h01, 1, 4, 8'h01, 1);
        add(1, 1, 0, 8'h05, 1, 0,  8'h02, 1, 4, 8'h05, 1);
        add(1, 0, 0, 8'h99, 1, 0,  8'h02, 1, 4, 8'h05, 1);
        add(1, 0, 0, 8'h99, 1, 1,  8'h02, 1, 4, 8'h04, 1);
        add(1, 0, 0, 8'h99, 1, 2,  8'h02, 1, 4, 8'h03, 1);
        add(1, 1, 0, 8'h06, 1, 3,  8'h03, 1, 4, 8'h03, 1);
        add(1, 1, 0, 8'h07, 1, 0,  8'h04, 1, 4, 8'h07, 1);
        add(1, 1, 1, 8'h77, 1, 0,  8'hA5, 0, 0, 8'hA5, 0);
        add(1, 1, 0, 8'h00, 0, 0,  8'hA5, 0, 0, 8'h00, 0);
        add(1, 1, 0, 8'h0A, 1, 1,  8'hA5, 0, 1, 8'h00, 0);
        add(1, 1, 0, 8'h0B, 0, 2,  8'hA5, 0, 1, 8'h00, 0);
        add(1, 1, 0, 8'h0C, 1, 3,  8'h00, 0, 2, 8'h00, 0);
        add(1, 1, 0, 8'h0D, 1, 0,  8'h0A, 1, 3, 8'h0D, 1);
        add(1, 0, 0, 8'h00, 0, 1,  8'h0A, 1, 3, 8'h0C, 1);
        add(1, 0, 0, 8'h00, 0, 2,  8'h0A, 1, 3, 8'h0B, 0);
        add(1, 0, 0, 8'h00, 0, 3,  8'h0A, 1, 3, 8'h0A, 1);
        add(1, 1, 0, 8'h0E, 0, 0,  8'h0B, 0, 2, 8'h0E, 0);
        add(1, 1, 0, 8'h0F, 0, 3,  8'h0C, 1, 2, 8'h0C, 1);
        add(1, 0, 1, 8'h00, 0, 2,  8'hA5, 0, 0, 8'hA5, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive_a(vecs[i].rst_n, vecs[i].en, vecs[i].fl, vecs[i].d, vecs[i].dv, vecs[i].ts);
            @(posedge clk);
            #1;
            check($sformatf("v%0d q", i),         32'(bus_a.q),         32'(vecs[i].eq));
            check($sformatf("v%0d q_valid", i),   32'(bus_a.q_valid),   32'(vecs[i].eqv));
            check($sformatf("v%0d count", i),     32'(bus_a.count),     32'(vecs[i].ecnt));
            check($sformatf("v%0d tap_q", i),     32'(bus_a.tap_q),     32'(vecs[i].etq));
            check($sformatf("v%0d tap_valid", i), 32'(bus_a.tap_valid), 32'(vecs[i].etv));
        end

        // Reset pulsed low strictly between edges must not disturb state.
        @(negedge clk);
        drive_a(1'b1, 1'b1, 1'b0, 8'h21, 1'b1, 2'd0);
        @(posedge clk); #1;
        check("glitch pre count", 32'(bus_a.count), 32'd1);
        @(negedge clk);
        drive_a(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0);
        #1 rst_a = 1'b0;
        #2 rst_a = 1'b1;
        @(posedge clk); #1;
        check("glitch count", 32'(bus_a.count), 32'd1);
        check("glitch tap_q", 32'(bus_a.tap_q), 32'h21);
        check("glitch tap_valid", 32'(bus_a.tap_valid), 32'd1);

        // Fill, then reset together with flush and a valid input.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_a(1'b1, 1'b1, 1'b0, 8'(8'h30 + i), 1'b1, 2'd3);
            @(posedge clk); #1;
        end
        check("full count", 32'(bus_a.count), 32'd4);
        check("full q", 32'(bus_a.q), 32'h30);
        @(negedge clk);
        drive_a(1'b0, 1'b1, 1'b1, 8'h77, 1'b1, 2'd3);
        @(posedge clk); #1;
        check("midrst q", 32'(bus_a.q), 32'hA5);
        check("midrst q_valid", 32'(bus_a.q_valid), 32'd0);
        check("midrst count", 32'(bus_a.count), 32'd0);
        check("midrst tap_valid", 32'(bus_a.tap_valid), 32'd0);

        // One entry, one stall cycle: q must see it on the 4th enabled edge.
        @(negedge clk);
        drive_a(1'b1, 1'b1, 1'b0, 8'h42, 1'b1, 2'd0);
        @(posedge clk); #1;
        en_edges = 1;
        hit = 0;
        q_seen = 8'h00;
        if (bus_a.q_valid) begin hit = en_edges; q_seen = bus_a.q; end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            drive_a(1'b1, (c == 1) ? 1'b0 : 1'b1, 1'b0, 8'h00, 1'b0, 2'd0);
            @(posedge clk); #1;
            if (c != 1) en_edges++;
            if (bus_a.q_valid && hit == 0) begin
                hit = en_edges;
                q_seen = bus_a.q;
            end
        end
        check("latency edges", 32'(hit), 32'd4);
        check("latency data", 32'(q_seen), 32'h42);

        // DEPTH=3: tap_sel=3 is out of range.
        @(negedge clk);
        bus_b.tap_sel = 2'd3;
        @(posedge clk); #1;
        check("b reset q", 32'(bus_b.q), 32'h3C);
        check("b reset tap_q", 32'(bus_b.tap_q), 32'h3C);
        check("b reset tap_valid", 32'(bus_b.tap_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst_b = 1'b1;
            bus_b.en = 1'b1;
            bus_b.d_valid = 1'b1;
            bus_b.d = 8'(8'h51 + i);
            @(posedge clk); #1;
        end
        check("b full q", 32'(bus_b.q), 32'h51);
        check("b full count", 32'(bus_b.count), 32'd3);
        check("b oor tap_q", 32'(bus_b.tap_q), 32'h3C);
        check("b oor tap_valid", 32'(bus_b.tap_valid), 32'd0);
        @(negedge clk);
        bus_b.en = 1'b0;
        bus_b.tap_sel = 2'd2;
        #1;
        check("b tap2 q", 32'(bus_b.tap_q), 32'h51);
        check("b tap2 valid", 32'(bus_b.tap_valid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
